// File: rtl/sample_stimulus_gen.sv
// sample_stimulus_gen: periodic test-sample source with a valid/ready output.
// A divider produces one tick every CLK_DIV clocks while enabled. Each tick
// produces a ramp, triangle, square or constant sample. The sample is held
// with o_valid until the downstream block accepts it. If a tick arrives while
// a sample is still pending, that tick is dropped and counted.
//
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_enable          run sample generation
//   i_mode            00 ramp, 01 triangle, 10 square, 11 constant
//   i_step            increment for ramp/triangle/square, or the constant value
//   o_data, o_valid   sample and its valid flag, toward the downstream i_data
//   i_ready           downstream accepts the sample
//   o_overrun         sticky flag, set when a tick is dropped
//   o_drop_cnt        saturating count of dropped ticks
module sample_stimulus_gen #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 27_000_000
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_enable,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_step,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_overrun,
    output logic [7:0]        o_drop_cnt
);

    localparam int unsigned DIV_W = 32;
    localparam int unsigned CNT_W = 8;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DATA_W-1:0] S_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] S_MIN    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_SAT  = '1;

    localparam logic [1:0] MODE_RAMP   = 2'b00;
    localparam logic [1:0] MODE_TRI    = 2'b01;
    localparam logic [1:0] MODE_SQUARE = 2'b10;
    localparam logic [1:0] MODE_CONST  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_COUNT = 2'b01,
        S_HOLD  = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic               dir_up_q, dir_up_d;
    logic               level_hi_q, level_hi_d;
    logic [1:0]         mode_q, mode_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic               tick_c;
    logic               xfer_c;
    logic               drop_c;
    logic               take_c;

    logic               mode_chg_c;
    logic [DATA_W-1:0]  acc_base_c;
    logic               dir_base_c;
    logic [DATA_W:0]    ramp_sum_c;
    logic [DATA_W:0]    tw_a_c;
    logic [DATA_W:0]    tw_b_c;
    logic [DATA_W:0]    tw_sum_c;
    logic [DATA_W-1:0]  sample_c;
    logic [DATA_W-1:0]  acc_nx_c;
    logic               dir_nx_c;
    logic               level_nx_c;

    // Tick, transfer and drop qualification.
    always_comb begin
        tick_c = i_enable && (div_q == DIV_LAST);
        xfer_c = valid_q && i_ready;
        // A tick is dropped only if the pending sample survives this edge.
        drop_c = tick_c && valid_q && !i_ready;
        take_c = tick_c && !drop_c;
    end

    // Next-sample computation; only committed when a tick is taken.
    always_comb begin
        mode_chg_c = (i_mode != mode_q);
        acc_base_c = mode_chg_c ? '0 : acc_q;
        dir_base_c = mode_chg_c ? 1'b1 : dir_up_q;
        ramp_sum_c = {1'b0, acc_base_c} + {1'b0, i_step};
        tw_a_c     = {acc_base_c[DATA_W-1], acc_base_c};
        tw_b_c     = {i_step[DATA_W-1], i_step};
        tw_sum_c   = dir_base_c ? (tw_a_c + tw_b_c) : (tw_a_c - tw_b_c);

        sample_c   = ramp_sum_c[DATA_W-1:0];
        acc_nx_c   = ramp_sum_c[DATA_W-1:0];
        dir_nx_c   = dir_base_c;
        level_nx_c = level_hi_q;

        case (i_mode)
            MODE_RAMP: begin
            end
            MODE_TRI: begin
                // Top two bits of the widened sum flag overflow past max/min.
                if (tw_sum_c[DATA_W:DATA_W-1] == 2'b01) begin
                    sample_c = S_MAX;
                    dir_nx_c = 1'b0;
                end else if (tw_sum_c[DATA_W:DATA_W-1] == 2'b10) begin
                    sample_c = S_MIN;
                    dir_nx_c = 1'b1;
                end else begin
                    sample_c = tw_sum_c[DATA_W-1:0];
                end
                acc_nx_c = sample_c;
            end
            MODE_SQUARE: begin
                // Carry out of the ramp accumulator marks a wrap.
                level_nx_c = ramp_sum_c[DATA_W] ? !level_hi_q : level_hi_q;
                sample_c   = level_nx_c ? S_MAX : S_MIN;
            end
            MODE_CONST: begin
                sample_c = i_step;
                acc_nx_c = acc_base_c;
            end
            default: begin
            end
        endcase
    end

    // FSM next state, divider, sample registers and drop accounting.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        acc_d      = acc_q;
        dir_up_d   = dir_up_q;
        level_hi_d = level_hi_q;
        mode_d     = mode_q;
        data_d     = data_q;
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;

        if (!i_enable || tick_c) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (take_c) begin
                    state_d = S_HOLD;
                end else if (i_enable) begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (tick_c) begin
                    state_d = S_HOLD;
                end else if (!i_enable) begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                // Tick coincident with a transfer reloads without a gap.
                if (xfer_c && !take_c) begin
                    state_d = i_enable ? S_COUNT : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (take_c) begin
            data_d     = sample_c;
            acc_d      = acc_nx_c;
            dir_up_d   = dir_nx_c;
            level_hi_d = level_nx_c;
            mode_d     = i_mode;
        end

        if (drop_c) begin
            overrun_d = 1'b1;
            if (drop_cnt_q != CNT_SAT) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end

        valid_d = (state_d == S_HOLD);
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            acc_q      <= '0;
            dir_up_q   <= 1'b1;
            level_hi_q <= 1'b1;
            mode_q     <= MODE_RAMP;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            acc_q      <= acc_d;
            dir_up_q   <= dir_up_d;
            level_hi_q <= level_hi_d;
            mode_q     <= mode_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_overrun  = overrun_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_sample_stimulus_gen.sv
// Bench for sample_stimulus_gen with CLK_DIV=4, DATA_W=8. Expected samples go
// into a queue when stimulus is set up; a monitor pops one per transfer.
module tb_sample_stimulus_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] mode;
    logic [7:0] step;
    logic [7:0] o_data;
    logic       o_valid;
    logic       ready;
    logic       o_overrun;
    logic [7:0] o_drop_cnt;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         valid_cycles = 0;
    logic [7:0] exp_q[$];
    int         xfer_cyc[$];

    sample_stimulus_gen #(
        .DATA_W (8),
        .CLK_DIV(4)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_enable  (enable),
        .i_mode    (mode),
        .i_step    (step),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (ready),
        .o_overrun (o_overrun),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: a transfer is valid && ready at the coming rising edge.
    always @(negedge clk) begin
        if (o_valid === 1'b1) valid_cycles++;
        if (rst_n === 1'b1 && o_valid === 1'b1 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_sample: got 0x%0h expected none (cycle %0d)", o_data, cyc);
            end else begin
                check("sample", 32'(o_data), 32'(exp_q.pop_front()));
            end
            xfer_cyc.push_back(cyc);
        end
    end

    task automatic step_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k = 0;
        while (o_valid !== 1'b1 && k < budget) begin
            step_cyc(1);
            k++;
        end
        check(name, 32'(o_valid), 32'd1);
    endtask

    task automatic wait_empty(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step_cyc(1);
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int vbase;

        rst_n  = 1'b0;
        enable = 1'b0;
        mode   = 2'b00;
        step   = 8'h00;
        ready  = 1'b0;
        step_cyc(3);
        check("reset_data",    32'(o_data),     32'd0);
        check("reset_valid",   32'(o_valid),    32'd0);
        check("reset_overrun", 32'(o_overrun),  32'd0);
        check("reset_dropcnt", 32'(o_drop_cnt), 32'd0);
        rst_n = 1'b1;
        step_cyc(2);

        // Ramp, always ready: one-cycle pulses four cycles apart.
        mode  = 2'b00;
        step  = 8'h40;
        ready = 1'b1;
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h40);
        base   = xfer_cyc.size();
        vbase  = valid_cycles;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("no_valid_after_enable", 32'(o_valid), 32'd0);
            step_cyc(1);
        end
        check("first_valid_latency", 32'(o_valid), 32'd1);
        wait_empty("ramp_done", 40);
        enable = 1'b0;
        check("ramp_xfers", 32'(xfer_cyc.size() - base), 32'd5);
        if (xfer_cyc.size() - base == 5) begin
            for (int i = 1; i < 5; i++) begin
                check("ramp_spacing", 32'(xfer_cyc[base+i] - xfer_cyc[base+i-1]), 32'd4);
            end
        end
        check("ramp_pulse_width", 32'(valid_cycles - vbase), 32'd5);
        step_cyc(2);

        // Triangle with clamping at both rails.
        mode = 2'b01;
        step = 8'h30;
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h60);
        exp_q.push_back(8'h7F);
        exp_q.push_back(8'h4F);
        exp_q.push_back(8'h1F);
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBF);
        exp_q.push_back(8'h8F);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'hB0);
        enable = 1'b1;
        wait_empty("triangle_done", 80);
        enable = 1'b0;
        step_cyc(2);

        // Backpressure: two ticks dropped while 0x40 is held.
        mode  = 2'b00;
        step  = 8'h40;
        ready = 1'b0;
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h80);
        enable = 1'b1;
        wait_valid("bp_valid", 20);
        step_cyc(8);
        check("bp_hold_data",  32'(o_data),     32'h40);
        check("bp_hold_valid", 32'(o_valid),    32'd1);
        check("bp_overrun",    32'(o_overrun),  32'd1);
        check("bp_dropcnt",    32'(o_drop_cnt), 32'd2);
        ready = 1'b1;
        wait_empty("bp_done", 30);
        enable = 1'b0;
        step_cyc(2);

        // Ready rises in the tick cycle: valid stays high, data steps.
        mode  = 2'b00;
        step  = 8'h10;
        ready = 1'b0;
        exp_q.push_back(8'h90);
        exp_q.push_back(8'hA0);
        enable = 1'b1;
        wait_valid("coin_valid", 20);
        for (int i = 0; i < 3; i++) begin
            check("coin_hold_valid", 32'(o_valid), 32'd1);
            check("coin_hold_data",  32'(o_data),  32'h90);
            step_cyc(1);
        end
        ready = 1'b1;
        check("coin_tick_valid", 32'(o_valid), 32'd1);
        step_cyc(1);
        check("coin_after_valid", 32'(o_valid),    32'd1);
        check("coin_after_data",  32'(o_data),     32'hA0);
        check("coin_no_drop",     32'(o_drop_cnt), 32'd2);
        wait_empty("coin_done", 20);
        enable = 1'b0;
        step_cyc(2);

        // Mode changes restart the accumulator.
        mode  = 2'b00;
        step  = 8'h10;
        ready = 1'b1;
        exp_q.push_back(8'hB0);
        enable = 1'b1;
        wait_empty("mc_ramp", 30);
        mode = 2'b11;
        step = 8'h5A;
        exp_q.push_back(8'h5A);
        wait_empty("mc_const", 30);
        mode = 2'b00;
        step = 8'h10;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20);
        wait_empty("mc_ramp_again", 30);
        enable = 1'b0;
        step_cyc(2);

        // Asynchronous reset mid-hold discards the pending sample.
        mode   = 2'b00;
        step   = 8'h40;
        ready  = 1'b0;
        enable = 1'b1;
        wait_valid("rst_hold_valid", 20);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_data",    32'(o_data),     32'd0);
        check("async_rst_valid",   32'(o_valid),    32'd0);
        check("async_rst_overrun", 32'(o_overrun),  32'd0);
        check("async_rst_dropcnt", 32'(o_drop_cnt), 32'd0);
        step_cyc(2);
        ready = 1'b1;
        exp_q.push_back(8'h40);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("no_valid_after_reset", 32'(o_valid), 32'd0);
            step_cyc(1);
        end
        check("post_reset_valid", 32'(o_valid), 32'd1);
        wait_empty("post_reset_done", 20);
        enable = 1'b0;
        step_cyc(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sample_stimulus_gen.md
SAMPLE_STIMULUS_GEN -- requirements
Module: sample_stimulus_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8: sample width, two's-complement Q1.(DATA_W-1).
REQ-002 SHALL have parameter CLK_DIV, default 27_000_000: clocks per sample tick; legal range 2 to 2^32-1.
REQ-003 SHALL have port i_clk, input, 1: single system clock; all logic is on its rising edge.
REQ-004 SHALL have port i_reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_enable, input, 1: run sample generation.
REQ-006 SHALL have port i_mode, input, 2: 00 ramp, 01 triangle, 10 square, 11 constant.
REQ-007 SHALL have port i_step, input, DATA_W: ramp/triangle increment, or the constant value.
REQ-008 SHALL have port o_data, output, DATA_W: sample toward the downstream DSP block's i_data.
REQ-009 SHALL have port o_valid, output, 1: o_data holds an unaccepted sample.
REQ-010 SHALL have port i_ready, input, 1: downstream accepts the sample.
REQ-011 SHALL have port o_overrun, output, 1: sticky flag, set when a tick is dropped.
REQ-012 SHALL have port o_drop_cnt, output, 8: count of dropped ticks, saturating.

Function
REQ-013 SHALL run a divider counter 0..CLK_DIV-1 while i_enable=1; tick in the cycle where counter = CLK_DIV-1, then wrap to 0.
REQ-014 SHALL hold the divider at 0 while i_enable=0; the first tick comes CLK_DIV cycles after enable rises.
REQ-015 SHALL use FSM states S_IDLE (disabled, nothing pending), S_COUNT (counting, nothing pending) and S_HOLD (o_valid=1).
REQ-016 SHALL make these FSM transitions: S_IDLE->S_COUNT on i_enable=1; S_COUNT->S_HOLD on tick; S_COUNT->S_IDLE on i_enable=0; S_HOLD->S_COUNT on transfer with enable=1, or S_IDLE with enable=0.
REQ-017 SHALL register each new sample on the tick edge and drive it with o_valid=1 from the next cycle (latency 1 clock).
REQ-018 SHALL define a transfer as o_valid and i_ready both high at a rising edge; o_data SHALL stay stable while o_valid=1 and no transfer has occurred.
REQ-019 SHALL, when a tick and a transfer fall in the same cycle, accept the old sample and load the new one, so o_valid stays 1 with no gap.
REQ-020 SHALL, on a tick while a sample is pending with no transfer that cycle, drop the tick: sample state not advanced, o_overrun set, o_drop_cnt incremented, saturating at 255.
REQ-021 SHALL, in ramp mode, compute next = acc + i_step modulo 2^DATA_W; the first sample after reset is i_step.
REQ-022 SHALL, in triangle mode, add i_step when the direction is up and subtract it when down, using DATA_W+1-bit signed arithmetic.
REQ-023 SHALL, in triangle mode, clamp a result above max (0x7F) to max and flip the direction to down, and clamp a result below min (0x80) to min and flip to up.
REQ-024 SHALL, in square mode, run the ramp accumulator internally and toggle the output between max and min each time the accumulator wraps; the output starts at max.
REQ-025 SHALL, in constant mode, output i_step on every tick.
REQ-026 SHALL sample i_mode only on a tick; when it differs from the previous tick's mode, reset acc to 0 and direction to up before computing the sample.
REQ-027 SHALL, when i_enable drops while in S_HOLD, keep the pending sample until it is transferred.

Reset
REQ-028 SHALL, while i_reset_n=0, asynchronously force o_data=0, o_valid=0, o_overrun=0, o_drop_cnt=0, divider=0, acc=0, direction=up, square level=max, state=S_IDLE.
REQ-029 SHALL, on reset assertion mid-hold, lose the pending sample; after release, the first sample comes CLK_DIV cycles after enable is seen.

Verification (CLK_DIV=4, DATA_W=8)
REQ-030 SHALL check reset: assert i_reset_n=0 asynchronously mid-cycle -> all outputs read 0 immediately; no o_valid for 4 cycles after enable.
REQ-031 SHALL check ramp: i_step=0x40, i_ready=1 -> o_data sequence 0x40,0x80,0xC0,0x00,0x40, each o_valid pulse one cycle, pulses 4 cycles apart.
REQ-032 SHALL check triangle: i_step=0x30 -> o_data sequence 0x30,0x60,0x7F,0x4F,0x1F,0xEF,0xBF,0x8F,0x80,0xB0.
REQ-033 SHALL check backpressure: ramp with i_step=0x40 and i_ready=0 for 12 cycles -> o_data held at 0x40, o_overrun=1, o_drop_cnt=2; after i_ready=1 the next sample is 0x80.
REQ-034 SHALL check a coincident tick and transfer: i_ready rises in the tick cycle -> o_valid stays 1 continuously and o_data steps to the next value.
REQ-035 SHALL check a mode change: after ramp samples, switch to constant with i_step=0x5A -> next sample 0x5A; switch back to ramp with i_step=0x10 -> 0x10, 0x20.
